centroid_divider: RTL and testbench

Sits directly downstream of the peak detector. Reassembles the six-word `peak_info` burst into the 30-bit weighted-index sum and the 30-bit intensity sum. A radix-2 restoring divider then computes the fixed-point centroid (weighted sum / intensity sum) and presents it with a one-cycle valid strobe and error/status flags. It runs in the inter-frame gap and finishes before the next frame's burst.

---
 rtl/centroid_divider.sv | 176 +++++++++++++++++
 tb/tb_centroid_divider.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/centroid_divider.sv
// Reassembles the six-word peak_info burst into weighted-index and intensity sums,
// then computes the fixed-point centroid with a radix-2 restoring divider.
module centroid_divider #(
  parameter int DATAWIDTH = 12,
  parameter int SUM_WIDTH = 30,
  parameter int FRAC_BITS = 4,
  parameter int INT_WIDTH = 11
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start_act,
  input  logic                           peak_valid,
  input  logic [DATAWIDTH-1:0]           peak_info,
  output logic [INT_WIDTH+FRAC_BITS-1:0] centroid,
  output logic                           centroid_valid,
  output logic                           centroid_err,
  output logic                           centroid_sat,
  output logic                           burst_err,
  output logic                           overrun,
  output logic                           busy
);

  localparam int QW = SUM_WIDTH + FRAC_BITS;
  localparam int OW = INT_WIDTH + FRAC_BITS;
  localparam int CW = $clog2(QW + 1);
  localparam int WW = 10;

  typedef enum logic [2:0] {IDLE, COLLECT, CHECK, DIVIDE, DONE} state_t;

  state_t               state;
  state_t               next_state;
  logic [SUM_WIDTH-1:0] m_sum;
  logic [SUM_WIDTH-1:0] n_sum;
  logic [2:0]           word_cnt;
  logic [CW-1:0]        iter_cnt;
  logic [QW-1:0]        dq;
  logic [SUM_WIDTH-1:0] rem;
  logic [SUM_WIDTH:0]   rem_shift;
  logic [SUM_WIDTH:0]   diff;
  logic                 trial_ge;
  logic                 ovr_seen;
  logic                 capture_first;
  logic                 capture_next;
  logic                 drop_burst;
  logic                 ovr_hit;
  logic                 finish;
  logic                 unused_bits;

  // dq holds the dividend and collects quotient bits as the dividend shifts out.
  assign rem_shift   = {rem, dq[QW-1]};
  assign diff        = rem_shift - {1'b0, n_sum};
  assign trial_ge    = rem_shift >= {1'b0, n_sum};
  assign unused_bits = ^{peak_info[DATAWIDTH-1:WW], diff[SUM_WIDTH]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (start_act) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (peak_valid) next_state = COLLECT;
        COLLECT: begin
          if (!peak_valid)          next_state = IDLE;
          else if (word_cnt == 3'd5) next_state = CHECK;
        end
        CHECK:   next_state = (n_sum == '0) ? DONE : DIVIDE;
        DIVIDE:  if (iter_cnt == CW'(1)) next_state = DONE;
        DONE:    next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    busy          = (state != IDLE);
    capture_first = (state == IDLE) && peak_valid;
    capture_next  = (state == COLLECT) && peak_valid;
    drop_burst    = (state == COLLECT) && !peak_valid;
    ovr_hit       = ((state == CHECK) || (state == DIVIDE) || (state == DONE))
                    && peak_valid && !ovr_seen;
    finish        = (state == DONE);
  end

  // Burst capture and divider datapath; start_act wipes everything in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_sum    <= '0;
      n_sum    <= '0;
      word_cnt <= '0;
      iter_cnt <= '0;
      dq       <= '0;
      rem      <= '0;
    end else if (start_act) begin
      m_sum    <= '0;
      n_sum    <= '0;
      word_cnt <= '0;
      iter_cnt <= '0;
      dq       <= '0;
      rem      <= '0;
    end else if (capture_first) begin
      m_sum[WW-1:0] <= peak_info[WW-1:0];
      word_cnt      <= 3'd1;
    end else if (capture_next) begin
      case (word_cnt)
        3'd1:    m_sum[WW +: WW]   <= peak_info[WW-1:0];
        3'd2:    m_sum[2*WW +: WW] <= peak_info[WW-1:0];
        3'd3:    n_sum[0 +: WW]    <= peak_info[WW-1:0];
        3'd4:    n_sum[WW +: WW]   <= peak_info[WW-1:0];
        default: n_sum[2*WW +: WW] <= peak_info[WW-1:0];
      endcase
      word_cnt <= word_cnt + 3'd1;
    end else if (drop_burst) begin
      m_sum    <= '0;
      n_sum    <= '0;
      word_cnt <= '0;
    end else if (state == CHECK) begin
      word_cnt <= '0;
      if (n_sum != '0) begin
        dq       <= {m_sum, {FRAC_BITS{1'b0}}};
        rem      <= '0;
        iter_cnt <= CW'(QW);
      end
    end else if (state == DIVIDE) begin
      rem      <= trial_ge ? diff[SUM_WIDTH-1:0] : rem_shift[SUM_WIDTH-1:0];
      dq       <= {dq[QW-2:0], trial_ge};
      iter_cnt <= iter_cnt - CW'(1);
    end
  end

  // Result and flags change only together with the strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      centroid       <= '0;
      centroid_valid <= 1'b0;
      centroid_err   <= 1'b0;
      centroid_sat   <= 1'b0;
    end else if (finish && !start_act) begin
      centroid_valid <= 1'b1;
      if (n_sum == '0) begin
        centroid     <= '0;
        centroid_err <= 1'b1;
        centroid_sat <= 1'b0;
      end else if (|dq[QW-1:OW]) begin
        centroid     <= '1;
        centroid_err <= 1'b0;
        centroid_sat <= 1'b1;
      end else begin
        centroid     <= dq[OW-1:0];
        centroid_err <= 1'b0;
        centroid_sat <= 1'b0;
      end
    end else begin
      centroid_valid <= 1'b0;
    end
  end

  // ovr_seen limits overrun to one pulse per peak_valid assertion while busy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      burst_err <= 1'b0;
      overrun   <= 1'b0;
      ovr_seen  <= 1'b0;
    end else begin
      burst_err <= drop_burst && !start_act;
      overrun   <= ovr_hit && !start_act;
      if (ovr_hit && !start_act) ovr_seen <= 1'b1;
      else if (!peak_valid)      ovr_seen <= 1'b0;
    end
  end

endmodule

// File: tb/tb_centroid_divider.sv
// Directed bench for centroid_divider: table of bursts with hand-computed
// centroids, plus hand-written protocol-error and abort sequences.
module tb_centroid_divider;

  logic        clk;
  logic        reset_n;
  logic        start_act;
  logic        peak_valid;
  logic [11:0] peak_info;
  logic [14:0] centroid;
  logic        centroid_valid;
  logic        centroid_err;
  logic        centroid_sat;
  logic        burst_err;
  logic        overrun;
  logic        busy;

  int tests;
  int fails;

  typedef struct {
    string       name;
    logic [29:0] m;
    logic [29:0] n;
    logic [1:0]  hi;
    logic [14:0] exp_c;
    logic        exp_err;
    logic        exp_sat;
    int          exp_lat;
  } vec_t;

  vec_t vecs[10];

  centroid_divider dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start_act      (start_act),
    .peak_valid     (peak_valid),
    .peak_info      (peak_info),
    .centroid       (centroid),
    .centroid_valid (centroid_valid),
    .centroid_err   (centroid_err),
    .centroid_sat   (centroid_sat),
    .burst_err      (burst_err),
    .overrun        (overrun),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives the first nwords words of a burst; hold keeps peak_valid high afterwards.
  task automatic applyStimulus(input logic [29:0] m, input logic [29:0] n,
                               input logic [1:0] hi, input int nwords, input bit hold);
    logic [59:0] words;
    words = {n, m};
    for (int i = 0; i < nwords; i++) begin
      peak_valid = 1'b1;
      peak_info  = {hi, words[i*10 +: 10]};
      cyc();
    end
    peak_info  = 12'h000;
    peak_valid = hold;
  endtask

  task automatic waitStrobe(input int budget, output int cycles, output bit seen);
    seen   = 1'b0;
    cycles = 0;
    for (int i = 1; i <= budget; i++) begin
      cyc();
      if (centroid_valid) begin
        seen   = 1'b1;
        cycles = i;
        break;
      end
    end
  endtask

  initial begin
    int  lat;
    bit  seen;
    logic [14:0] last_c;

    tests = 0;
    fails = 0;

    vecs[0] = '{"single_pixel", 30'd3700,    30'd100,        2'b00, 15'h0250, 1'b0, 1'b0, 36};
    vecs[1] = '{"two_pixels",   30'd21,      30'd2,          2'b00, 15'd168,  1'b0, 1'b0, 36};
    vecs[2] = '{"truncation",   30'd10,      30'd3,          2'b00, 15'd53,   1'b0, 1'b0, 36};
    vecs[3] = '{"zero_n",       30'd0,       30'd0,          2'b00, 15'd0,    1'b1, 1'b0, 2};
    vecs[4] = '{"sat_2p29",     30'h2000_0000, 30'd1,        2'b00, 15'h7FFF, 1'b0, 1'b1, 36};
    vecs[5] = '{"upper_ignored",30'd3700,    30'd100,        2'b11, 15'h0250, 1'b0, 1'b0, 36};
    vecs[6] = '{"max_fit",      30'd2047,    30'd1,          2'b10, 15'h7FF0, 1'b0, 1'b0, 36};
    vecs[7] = '{"just_sat",     30'd2048,    30'd1,          2'b01, 15'h7FFF, 1'b0, 1'b1, 36};
    vecs[8] = '{"mid_value",    30'd100000,  30'd77,         2'b00, 15'd20779,1'b0, 1'b0, 36};
    vecs[9] = '{"full_scale",   30'h3FFF_FFFF, 30'h3FFF_FFFF, 2'b00, 15'd16,  1'b0, 1'b0, 36};

    reset_n    = 1'b0;
    start_act  = 1'b0;
    peak_valid = 1'b0;
    peak_info  = 12'h000;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc();

    checkOutput("reset_centroid", 32'(centroid), 32'd0);
    checkOutput("reset_valid",    32'(centroid_valid), 32'd0);
    checkOutput("reset_err",      32'(centroid_err), 32'd0);
    checkOutput("reset_sat",      32'(centroid_sat), 32'd0);
    checkOutput("reset_burst_err",32'(burst_err), 32'd0);
    checkOutput("reset_overrun",  32'(overrun), 32'd0);
    checkOutput("reset_busy",     32'(busy), 32'd0);

    for (int v = 0; v < 10; v++) begin
      applyStimulus(vecs[v].m, vecs[v].n, vecs[v].hi, 6, 1'b0);
      checkOutput({vecs[v].name, "_busy"}, 32'(busy), 32'd1);
      waitStrobe(100, lat, seen);
      checkOutput({vecs[v].name, "_strobe"}, 32'(seen), 32'd1);
      checkOutput({vecs[v].name, "_latency"}, 32'(lat), 32'(vecs[v].exp_lat));
      checkOutput({vecs[v].name, "_centroid"}, 32'(centroid), 32'(vecs[v].exp_c));
      checkOutput({vecs[v].name, "_err"}, 32'(centroid_err), 32'(vecs[v].exp_err));
      checkOutput({vecs[v].name, "_sat"}, 32'(centroid_sat), 32'(vecs[v].exp_sat));
      checkOutput({vecs[v].name, "_idle"}, 32'(busy), 32'd0);
      cyc();
      checkOutput({vecs[v].name, "_strobe_one_cycle"}, 32'(centroid_valid), 32'd0);
    end

    // Short burst: three words then peak_valid drops in cycle 3.
    applyStimulus(30'd3700, 30'd100, 2'b00, 3, 1'b0);
    cyc();
    checkOutput("short_burst_err", 32'(burst_err), 32'd1);
    checkOutput("short_busy", 32'(busy), 32'd0);
    cyc();
    checkOutput("short_burst_err_pulse", 32'(burst_err), 32'd0);
    waitStrobe(50, lat, seen);
    checkOutput("short_no_strobe", 32'(seen), 32'd0);

    // Burst arriving mid-divide is dropped; the running result completes.
    applyStimulus(30'd21, 30'd2, 2'b00, 6, 1'b0);
    repeat (10) cyc();
    peak_valid = 1'b1;
    peak_info  = 12'h3FF;
    cyc();
    checkOutput("divide_overrun", 32'(overrun), 32'd1);
    cyc();
    checkOutput("divide_overrun_pulse", 32'(overrun), 32'd0);
    peak_valid = 1'b0;
    peak_info  = 12'h000;
    waitStrobe(100, lat, seen);
    checkOutput("overrun_strobe", 32'(seen), 32'd1);
    checkOutput("overrun_latency", 32'(lat), 32'd24);
    checkOutput("overrun_centroid", 32'(centroid), 32'd168);

    // Seventh consecutive valid cycle lands in CHECK.
    applyStimulus(30'd10, 30'd3, 2'b00, 6, 1'b1);
    cyc();
    checkOutput("seventh_overrun", 32'(overrun), 32'd1);
    peak_valid = 1'b0;
    waitStrobe(100, lat, seen);
    checkOutput("seventh_strobe", 32'(seen), 32'd1);
    checkOutput("seventh_latency", 32'(lat), 32'd35);
    checkOutput("seventh_centroid", 32'(centroid), 32'd53);
    last_c = 15'd53;

    // start_act in cycle 20 aborts a saturating computation.
    applyStimulus(30'h2000_0000, 30'd1, 2'b00, 6, 1'b0);
    repeat (14) cyc();
    start_act = 1'b1;
    cyc();
    start_act = 1'b0;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    waitStrobe(45, lat, seen);
    checkOutput("abort_no_strobe", 32'(seen), 32'd0);
    checkOutput("abort_centroid_hold", 32'(centroid), 32'(last_c));
    checkOutput("abort_sat_hold", 32'(centroid_sat), 32'd0);
    applyStimulus(30'd3700, 30'd100, 2'b00, 6, 1'b0);
    waitStrobe(100, lat, seen);
    checkOutput("after_abort_strobe", 32'(seen), 32'd1);
    checkOutput("after_abort_latency", 32'(lat), 32'd36);
    checkOutput("after_abort_centroid", 32'(centroid), 32'h250);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
